param_shift_register: RTL and testbench

- Parametrised successor to the team's fixed 3-bit parallel-in/parallel-out register.
- Adds four operating modes: hold, shift right, shift left and parallel load.
- Adds serial input and output taps, plus an auto-serialise engine that loads a word and shifts it out LSB-first, WIDTH bits in total.
- Sits between parallel datapaths and bit-serial links (UART/SPI-style framers) in the same design.

---
 rtl/param_shift_register_pkg.sv | 18 +
 rtl/param_shift_register_shift_core.sv | 48 ++++
 rtl/param_shift_register.sv | 144 ++++++++++++++
 tb/tb_param_shift_register.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/param_shift_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : param_shift_pkg
// Description : Mode and FSM state encodings shared by the shift register files.
// Revision    : 1.0 - initial release
// ============================================================================
package param_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/param_shift_register_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : shift_core
// Description : WIDTH-bit register with hold / shift-right / shift-left / load mux.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_core
    import param_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;

    always_comb begin
        dout_d = dout_q;
        if (en) begin
            case (mode)
                MODE_SHR:  dout_d = {ser_in_msb, dout_q[WIDTH-1:1]};
                MODE_SHL:  dout_d = {dout_q[WIDTH-2:0], ser_in_lsb};
                MODE_LOAD: dout_d = datain;
                default:   dout_d = dout_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule
`default_nettype wire

// File: rtl/param_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : param_shift_register
// Description : Mode-controlled shift register with an LSB-first auto-serialiser.
//               Define PARAM_SHIFT_PARITY_EN to append a parity bit to each word.
// Revision    : 1.0 - initial release
// ============================================================================
module param_shift_register
    import param_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] datain,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt
`ifdef PARAM_SHIFT_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef PARAM_SHIFT_PARITY_EN
    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(WIDTH + 1);
`else
    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(WIDTH);
`endif

    logic [0:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             done_d, done_q;
    logic             busy_d, busy_q;
    logic             core_en;
    logic [1:0]       core_mode;

    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .en         (core_en),
        .mode       (core_mode),
        .ser_in_msb (ser_in_msb),
        .ser_in_lsb (ser_in_lsb),
        .datain     (datain),
        .dout       (dout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = RUN_LEN;
                end
            end
            default: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

`ifdef PARAM_SHIFT_PARITY_EN
    logic parity_d, parity_q;

    always_comb begin
        parity_d = parity_q;
        if (state_q == ST_IDLE && start) begin
            parity_d = ^datain;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_out = parity_q;
`endif

    // start overrides the user mode in IDLE; RUN always forces a right shift
    always_comb begin
        core_en   = en;
        core_mode = mode;
        ser_out   = dout[0];
        if (state_q == ST_IDLE) begin
            if (start) begin
                core_en   = 1'b1;
                core_mode = MODE_LOAD;
            end
        end else begin
            core_en   = 1'b1;
            core_mode = MODE_SHR;
`ifdef PARAM_SHIFT_PARITY_EN
            if (cnt_q == CNT_ONE) begin
                core_en = 1'b0;
                ser_out = parity_q;
            end
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign shift_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_param_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_shift_register
// Description : Directed scoreboard bench for param_shift_register (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_shift_register;

    logic       clock;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       ser_in_msb;
    logic       ser_in_lsb;
    logic [7:0] datain;
    logic       start;
    logic [7:0] dout;
    logic       ser_out;
    logic       busy;
    logic       done;
    logic [3:0] shift_cnt;
`ifdef PARAM_SHIFT_PARITY_EN
    logic       parity_out;
`endif

    param_shift_register #(
        .WIDTH (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .ser_in_msb (ser_in_msb),
        .ser_in_lsb (ser_in_lsb),
        .datain     (datain),
        .start      (start),
        .dout       (dout),
        .ser_out    (ser_out),
        .busy       (busy),
        .done       (done),
        .shift_cnt  (shift_cnt)
`ifdef PARAM_SHIFT_PARITY_EN
        ,
        .parity_out (parity_out)
`endif
    );

    typedef struct {
        logic [7:0] dout;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
        logic       ser;
        logic       par;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: every settled cycle, compare the DUT against the queued expectation
    always @(negedge clock) begin
        while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            check("dout",      dout,             e.dout);
            check("busy",      {7'd0, busy},     {7'd0, e.busy});
            check("done",      {7'd0, done},     {7'd0, e.done});
            check("shift_cnt", {4'd0, shift_cnt}, {4'd0, e.cnt});
            check("ser_out",   {7'd0, ser_out},  {7'd0, e.ser});
`ifdef PARAM_SHIFT_PARITY_EN
            check("parity_out", {7'd0, parity_out}, {7'd0, e.par});
`endif
        end
    end

    // One clock edge with the current inputs; queue the state expected after it
    task automatic tick(input logic [7:0] d, input logic b, input logic dn,
                        input logic [3:0] c, input logic s, input logic p);
        exp_t e;
        @(posedge clock);
        e.dout = d; e.busy = b; e.done = dn; e.cnt = c; e.ser = s; e.par = p;
        expq.push_back(e);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; en = 1'b1; mode = 2'b11;
        datain = 8'hFF; ser_in_msb = 1'b1; ser_in_lsb = 1'b1;
        tick(8'h00, 0, 0, 4'd0, 0, 0);
        start = 1'b0; mode = 2'b01; datain = 8'h5A;
        tick(8'h00, 0, 0, 4'd0, 0, 0);

        reset = 1'b0; en = 1'b1; mode = 2'b11; datain = 8'hA5;
        ser_in_msb = 1'b0; ser_in_lsb = 1'b0;
        tick(8'hA5, 0, 0, 4'd0, 1, 0);
        mode = 2'b01; ser_in_msb = 1'b1;
        tick(8'hD2, 0, 0, 4'd0, 0, 0);
        tick(8'hE9, 0, 0, 4'd0, 1, 0);

        mode = 2'b11; datain = 8'h81;
        tick(8'h81, 0, 0, 4'd0, 1, 0);
        mode = 2'b10; ser_in_lsb = 1'b0;
        tick(8'h02, 0, 0, 4'd0, 0, 0);
        en = 1'b0; mode = 2'b11; datain = 8'hFF;
        for (int i = 0; i < 3; i++) tick(8'h02, 0, 0, 4'd0, 0, 0);

`ifdef PARAM_SHIFT_PARITY_EN
        // 8'h07 has odd parity: three ones, then five zeros, then the parity bit
        start = 1'b1; datain = 8'h07; ser_in_msb = 1'b0;
        tick(8'h07, 1, 0, 4'd9, 1, 1);
        start = 1'b0;
        tick(8'h03, 1, 0, 4'd8, 1, 1);
        tick(8'h01, 1, 0, 4'd7, 1, 1);
        tick(8'h00, 1, 0, 4'd6, 0, 1);
        tick(8'h00, 1, 0, 4'd5, 0, 1);
        tick(8'h00, 1, 0, 4'd4, 0, 1);
        tick(8'h00, 1, 0, 4'd3, 0, 1);
        tick(8'h00, 1, 0, 4'd2, 0, 1);
        tick(8'h00, 1, 0, 4'd1, 1, 1);
        tick(8'h00, 0, 1, 4'd0, 0, 1);
        tick(8'h00, 0, 0, 4'd0, 0, 1);
`else
        start = 1'b1; datain = 8'h35; ser_in_msb = 1'b0;
        tick(8'h35, 1, 0, 4'd8, 1, 0);
        start = 1'b0;
        tick(8'h1A, 1, 0, 4'd7, 0, 0);
        tick(8'h0D, 1, 0, 4'd6, 1, 0);
        start = 1'b1; datain = 8'hC3;
        tick(8'h06, 1, 0, 4'd5, 0, 0);
        start = 1'b0; en = 1'b1; mode = 2'b11; datain = 8'hAA;
        tick(8'h03, 1, 0, 4'd4, 1, 0);
        tick(8'h01, 1, 0, 4'd3, 1, 0);
        en = 1'b0;
        tick(8'h00, 1, 0, 4'd2, 0, 0);
        tick(8'h00, 1, 0, 4'd1, 0, 0);
        tick(8'h00, 0, 1, 4'd0, 0, 0);

        // back-to-back word started in the done cycle
        start = 1'b1; datain = 8'hFF;
        tick(8'hFF, 1, 0, 4'd8, 1, 0);
        start = 1'b0;
        tick(8'h7F, 1, 0, 4'd7, 1, 0);
        tick(8'h3F, 1, 0, 4'd6, 1, 0);
        tick(8'h1F, 1, 0, 4'd5, 1, 0);
        tick(8'h0F, 1, 0, 4'd4, 1, 0);
        reset = 1'b1;
        tick(8'h00, 0, 0, 4'd0, 0, 0);
        reset = 1'b0;
        tick(8'h00, 0, 0, 4'd0, 0, 0);
        tick(8'h00, 0, 0, 4'd0, 0, 0);
`endif

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
